exu_oitf: RTL

Outstanding Instruction Track FIFO for the two-stage EXU.
- Records every long-pipe instruction accepted by the dispatch stage and hands it an itag.
- Retires entries in program order when the long-pipe writeback arbiter commits them.
- Flags RAW/WAW hazards of the instruction currently at dispatch against all in-flight destinations, so dispatch can stall.

---
 rtl/exu_oitf_pkg.sv | 10 +
 rtl/exu_oitf_ptr.sv | 45 ++++
 rtl/exu_oitf.sv | 134 +++++++++++++
 3 files changed

// File: rtl/exu_oitf_pkg.sv
// Shared sizing for the EXU outstanding-instruction track FIFO.
// The itag width is derived from the depth so the two cannot drift apart.
package exu_oitf_pkg;

  localparam int E203_OITF_DEPTH  = 2;
  localparam int E203_RFIDX_WIDTH = 5;
  localparam int E203_PC_SIZE     = 32;
  localparam int E203_ITAG_WIDTH  = $clog2(E203_OITF_DEPTH);

endpackage

// File: rtl/exu_oitf_ptr.sv
// Circular pointer with a wrap flag.
// The flag lets equal pointers be told apart as full or empty.
module exu_oitf_ptr #(
  parameter int DEPTH = 2,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o,
  output logic         flg_o
);

  localparam logic [W-1:0] LAST = W'(DEPTH - 1);

  logic [W-1:0] ptr_q, ptr_d;
  logic         flg_q, flg_d;

  always_comb begin
    ptr_d = ptr_q;
    flg_d = flg_q;
    if (inc_i) begin
      if (ptr_q == LAST) begin
        ptr_d = '0;
        flg_d = ~flg_q;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      flg_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      flg_q <= flg_d;
    end
  end

  assign ptr_o = ptr_q;
  assign flg_o = flg_q;

endmodule

// File: rtl/exu_oitf.sv
// Outstanding instruction track FIFO: hands out itags to long-pipe
// instructions, retires them in order and flags dispatch hazards.
module exu_oitf
  import exu_oitf_pkg::*;
#(
  parameter int DEPTH       = E203_OITF_DEPTH,
  parameter int RFIDX_WIDTH = E203_RFIDX_WIDTH,
  parameter int PC_SIZE     = E203_PC_SIZE,
  parameter int ITAG_WIDTH  = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   dis_ena,
  output logic                   dis_ready,
  output logic [ITAG_WIDTH-1:0]  dis_ptr,
  input  logic                   ret_ena,
  output logic [ITAG_WIDTH-1:0]  ret_ptr,
  output logic [RFIDX_WIDTH-1:0] ret_rdidx,
  output logic                   ret_rdwen,
  output logic                   ret_rdfpu,
  output logic [PC_SIZE-1:0]     ret_pc,
  input  logic                   disp_i_rs1en,
  input  logic                   disp_i_rs2en,
  input  logic                   disp_i_rs3en,
  input  logic                   disp_i_rdwen,
  input  logic                   disp_i_rs1fpu,
  input  logic                   disp_i_rs2fpu,
  input  logic                   disp_i_rs3fpu,
  input  logic                   disp_i_rdfpu,
  input  logic [RFIDX_WIDTH-1:0] disp_i_rs1idx,
  input  logic [RFIDX_WIDTH-1:0] disp_i_rs2idx,
  input  logic [RFIDX_WIDTH-1:0] disp_i_rs3idx,
  input  logic [RFIDX_WIDTH-1:0] disp_i_rdidx,
  input  logic [PC_SIZE-1:0]     disp_i_pc,
  output logic                   oitfrd_match_disprs1,
  output logic                   oitfrd_match_disprs2,
  output logic                   oitfrd_match_disprs3,
  output logic                   oitfrd_match_disprd,
  output logic                   oitf_empty
);

  logic [ITAG_WIDTH-1:0] alc_ptr;
  logic                  alc_flg, ret_flg;
  logic                  full, empty;
  logic                  alc_fire, ret_fire;

  logic [DEPTH-1:0]       vld_q, vld_d;
  logic [DEPTH-1:0]       rdwen_q, rdfpu_q;
  logic [RFIDX_WIDTH-1:0] rdidx_q [DEPTH];
  logic [PC_SIZE-1:0]     pc_q    [DEPTH];

  logic [DEPTH-1:0] hit1, hit2, hit3, hitd;

  assign full  = (alc_ptr == ret_ptr) & (alc_flg != ret_flg);
  assign empty = (alc_ptr == ret_ptr) & (alc_flg == ret_flg);

  assign alc_fire = dis_ena & ~full;
  assign ret_fire = ret_ena & ~empty;

  exu_oitf_ptr #(.DEPTH(DEPTH), .W(ITAG_WIDTH)) u_alc_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (alc_fire),
    .ptr_o (alc_ptr),
    .flg_o (alc_flg)
  );

  exu_oitf_ptr #(.DEPTH(DEPTH), .W(ITAG_WIDTH)) u_ret_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (ret_fire),
    .ptr_o (ret_ptr),
    .flg_o (ret_flg)
  );

  // Alloc and retire slots differ whenever both may fire.
  always_comb begin
    vld_d = vld_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (ret_fire && ret_ptr == ITAG_WIDTH'(i)) vld_d[i] = 1'b0;
      if (alc_fire && alc_ptr == ITAG_WIDTH'(i)) vld_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_q <= '0;
    else        vld_q <= vld_d;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (alc_fire && alc_ptr == ITAG_WIDTH'(i)) begin
        rdwen_q[i] <= disp_i_rdwen;
        rdfpu_q[i] <= disp_i_rdfpu;
        rdidx_q[i] <= disp_i_rdidx;
        pc_q[i]    <= disp_i_pc;
      end
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic live;
    assign live    = vld_q[i] & rdwen_q[i];
    assign hit1[i] = live & disp_i_rs1en & (rdfpu_q[i] == disp_i_rs1fpu)
                   & (rdidx_q[i] == disp_i_rs1idx);
    assign hit2[i] = live & disp_i_rs2en & (rdfpu_q[i] == disp_i_rs2fpu)
                   & (rdidx_q[i] == disp_i_rs2idx);
    assign hit3[i] = live & disp_i_rs3en & (rdfpu_q[i] == disp_i_rs3fpu)
                   & (rdidx_q[i] == disp_i_rs3idx);
    assign hitd[i] = live & disp_i_rdwen & (rdfpu_q[i] == disp_i_rdfpu)
                   & (rdidx_q[i] == disp_i_rdidx);
  end

  assign oitfrd_match_disprs1 = |hit1;
  assign oitfrd_match_disprs2 = |hit2;
  assign oitfrd_match_disprs3 = |hit3;
  assign oitfrd_match_disprd  = |hitd;

  assign dis_ready  = ~full;
  assign dis_ptr    = alc_ptr;
  assign oitf_empty = empty;

  assign ret_rdidx = rdidx_q[ret_ptr];
  assign ret_rdwen = rdwen_q[ret_ptr];
  assign ret_rdfpu = rdfpu_q[ret_ptr];
  assign ret_pc    = pc_q[ret_ptr];

  // A blocked allocate alongside a retire from full is a legal overlap.
  a_no_alc_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(dis_ena && full && !ret_ena));
  a_no_ret_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(ret_ena && empty));

endmodule
